random_victim_ctrl: RTL and testbench
=====================================

// Module: random_victim_ctrl
// PURPOSE
//  Replacement controller for the set-associative TTCache. On each miss it picks the way to refill.
//  It prefers an invalid, unlocked way. Otherwise it draws random ways from an internal Fibonacci LFSR until it hits an unlocked way.
//  Sits between the miss handler (requester) and the refill/tag-write path (consumer).
// PARAMETERS
//  WAYS       4      number of ways per set (2..2**WAY_BITS)
//  WAY_BITS   2      width of a way index
//  LFSR_BITS  5      LFSR width (>= WAY_BITS)
//  SEED       5'h1f  reset/default LFSR value; must be nonzero
//  MAX_DRAWS  8      random draws allowed before the deterministic fallback
// PORTS
//  clk          in   1          single clock, rising edge
//  rst_n        in   1          asynchronous, active-low reset
//  req_valid    in   1          miss handler requests a victim
//  req_ready    out  1          controller can accept a request (high only in IDLE)
//  valid_vec    in   WAYS       per-way valid bits of the target set; sampled on accept
//  lock_vec     in   WAYS       per-way lock bits (way must not be evicted); sampled on accept
//  resp_valid   out  1          victim result available
//  resp_ready   in   1          consumer takes the result
//  resp_way     out  WAY_BITS   chosen victim way
//  resp_random  out  1          1 = way came from an LFSR draw
//  resp_none    out  1          1 = every way locked; resp_way = 0, no eviction allowed
//  seed_load    in   1          load seed_value into LFSR (honoured in IDLE only)
//  seed_value   in   LFSR_BITS  new seed; 0 is replaced by SEED
//  lfsr_state   out  LFSR_BITS  current LFSR value (debug/verification)
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - state = IDLE, lfsr = SEED, draw_cnt = 0.
//   - resp_valid, resp_way, resp_random and resp_none all = 0.
//   - req_ready = 1.
//  LFSR step: next = {q[LFSR_BITS-1]^q[1], q[LFSR_BITS-1:1]}; one step per DRAW cycle, no other advance.
//  FSM: IDLE -> SCAN -> (RESP | DRAW) ; DRAW -> (DRAW | RESP) ; RESP -> IDLE.
//  IDLE:
//   - req_ready = 1.
//   - On req_valid: latch valid_vec/lock_vec, clear draw_cnt, go to SCAN.
//   - seed_load in IDLE: lfsr <= (seed_value != 0) ? seed_value : SEED. This takes priority over the LFSR hold; a request in the same cycle is still accepted.
//   - seed_load outside IDLE is ignored.
//  SCAN (1 cycle):
//   - free = ~valid & ~lock. If free != 0: resp_way = lowest set index, resp_random = 0, go to RESP.
//   - Else if &lock: resp_none = 1, resp_way = 0, go to RESP.
//   - Else go to DRAW.
//  DRAW (1 cycle per draw):
//   - LFSR steps. cand = next[WAY_BITS-1:0]. draw_cnt++.
//   - If cand < WAYS and !lock[cand]: resp_way = cand, resp_random = 1, go to RESP.
//   - Else if draw_cnt == MAX_DRAWS-1 (this was the last draw): resp_way = lowest unlocked way, resp_random = 0, go to RESP.
//   - Else stay in DRAW.
//  RESP:
//   - resp_valid = 1. resp_way, resp_random and resp_none are stable until resp_valid && resp_ready; then go to IDLE and clear resp_valid.
//   - Outputs are registered. resp_none and resp_random are cleared on every accept.
//  Latency from the accept edge: free/none case -> resp_valid 2 cycles later. Random case -> 2 + n cycles for n draws (n <= MAX_DRAWS).
//  Throughput: one request in flight. Next accept no earlier than the cycle after the response handshake.
//  Reset mid-operation: abandon the request immediately, return to reset values, LFSR = SEED.
//  valid_vec/lock_vec changes after accept have no effect on the current decision.
// STRUCTURE
//  Shared package ttcache_pkg holds:
//   - FSM state encoding localparams (IDLE, SCAN, DRAW, RESP; 2-bit).
//   - LFSR tap constant and default SEED.
//  One sub-module: lfsr_step_reg.
//   - Ports: clk, rst_n, advance, load, load_value, q.
//   - Clocked Fibonacci LFSR with the step rule above; zero-seed guard lives here.
//  Top level: FSM, latched vectors, priority encoder (lowest-index function), draw counter.
// TESTING
//  1 Reset: rst_n=0 for 2 cycles -> lfsr_state=5'h1f, req_ready=1, resp_valid=0, all resp_* = 0.
//  2 Free way: valid=4'b1011, lock=0 -> resp_way=2, random=0, none=0, resp_valid 2 cycles after accept.
//  3 Random draw: seed 1f, valid=4'hf, lock=0 -> one draw (lfsr=5'h0f), resp_way=3, random=1, resp_valid 3 cycles after accept.
//  4 Locked rejection: seed 1f, valid=4'hf, lock=4'b1000 -> lfsr 0f,17,0b,15 -> resp_way=1 after 4 draws, random=1.
//  5 All locked: lock=4'hf -> resp_none=1, resp_way=0. MAX_DRAWS=1 with lock=4'b1000 -> fallback resp_way=0, random=0.
//  6 Backpressure/reset:
//    - resp_ready=0 for 5 cycles -> outputs stable, req_ready=0.
//    - seed_load during DRAW -> ignored.
//    - seed_value=0 in IDLE -> lfsr=1f.
//    - rst_n low mid-DRAW -> IDLE, lfsr=1f next cycle.

Source files
------------

// File: rtl/ttcache_pkg.sv
// Shared TTCache definitions: replacement FSM encoding and LFSR constants.
package ttcache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DRAW = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    // Feedback is q[MSB] ^ q[LFSR_TAP]; the register shifts toward bit 0.
    localparam int         LFSR_TAP     = 1;
    localparam logic [4:0] DEFAULT_SEED = 5'h1f;

endpackage

// File: rtl/lfsr_step_reg.sv
// Clocked Fibonacci LFSR that advances one step on request.
// A zero load value is replaced by SEED so the register never locks up at zero.
module lfsr_step_reg
    import ttcache_pkg::*;
#(
    parameter int              BITS = 5,
    parameter logic [BITS-1:0] SEED = BITS'(DEFAULT_SEED)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            advance,
    input  logic            load,
    input  logic [BITS-1:0] load_value,
    output logic [BITS-1:0] q
);

    logic [BITS-1:0] next_q;

    always_comb begin
        next_q = {q[BITS-1] ^ q[LFSR_TAP], q[BITS-1:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= SEED;
        end else if (load) begin
            q <= (load_value != '0) ? load_value : SEED;
        end else if (advance) begin
            q <= next_q;
        end
    end

endmodule

// File: rtl/random_victim_ctrl.sv
// TTCache victim selection: prefer a free way, otherwise draw random unlocked ways
// from the LFSR, falling back to the lowest unlocked way after MAX_DRAWS draws.
module random_victim_ctrl
    import ttcache_pkg::*;
#(
    parameter int                   WAYS      = 4,
    parameter int                   WAY_BITS  = 2,
    parameter int                   LFSR_BITS = 5,
    parameter logic [LFSR_BITS-1:0] SEED      = LFSR_BITS'(DEFAULT_SEED),
    parameter int                   MAX_DRAWS = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [WAYS-1:0]      valid_vec,
    input  logic [WAYS-1:0]      lock_vec,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [WAY_BITS-1:0]  resp_way,
    output logic                 resp_random,
    output logic                 resp_none,
    input  logic                 seed_load,
    input  logic [LFSR_BITS-1:0] seed_value,
    output logic [LFSR_BITS-1:0] lfsr_state
);

    localparam int CNT_W = $clog2(MAX_DRAWS + 1);

    state_t               state;
    logic [WAYS-1:0]      valid_q;
    logic [WAYS-1:0]      lock_q;
    logic [CNT_W-1:0]     draw_cnt;
    logic [WAYS-1:0]      free_vec;
    logic [LFSR_BITS-1:0] lfsr_next;
    logic [WAY_BITS-1:0]  cand;
    logic                 cand_ok;
    logic                 lfsr_advance;
    logic                 lfsr_load;

    function automatic logic [WAY_BITS-1:0] lowest_index(input logic [WAYS-1:0] vec);
        logic [WAY_BITS-1:0] idx;
        idx = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = WAY_BITS'(i);
            end
        end
        return idx;
    endfunction

    // The candidate is taken from the value the LFSR moves to on this DRAW edge.
    always_comb begin
        free_vec  = ~valid_q & ~lock_q;
        lfsr_next = {lfsr_state[LFSR_BITS-1] ^ lfsr_state[LFSR_TAP], lfsr_state[LFSR_BITS-1:1]};
        cand      = lfsr_next[WAY_BITS-1:0];
        cand_ok   = 1'b0;
        for (int i = 0; i < WAYS; i++) begin
            if ((cand == WAY_BITS'(i)) && !lock_q[i]) begin
                cand_ok = 1'b1;
            end
        end
    end

    assign lfsr_advance = (state == ST_DRAW);
    assign lfsr_load    = seed_load && (state == ST_IDLE);

    lfsr_step_reg #(
        .BITS (LFSR_BITS),
        .SEED (SEED)
    ) u_lfsr (
        .clk        (clk),
        .rst_n      (rst_n),
        .advance    (lfsr_advance),
        .load       (lfsr_load),
        .load_value (seed_value),
        .q          (lfsr_state)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            valid_q     <= '0;
            lock_q      <= '0;
            draw_cnt    <= '0;
            req_ready   <= 1'b1;
            resp_valid  <= 1'b0;
            resp_way    <= '0;
            resp_random <= 1'b0;
            resp_none   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        valid_q     <= valid_vec;
                        lock_q      <= lock_vec;
                        draw_cnt    <= '0;
                        resp_random <= 1'b0;
                        resp_none   <= 1'b0;
                        req_ready   <= 1'b0;
                        state       <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (|free_vec) begin
                        resp_way    <= lowest_index(free_vec);
                        resp_random <= 1'b0;
                        resp_valid  <= 1'b1;
                        state       <= ST_RESP;
                    end else if (&lock_q) begin
                        resp_way    <= '0;
                        resp_none   <= 1'b1;
                        resp_valid  <= 1'b1;
                        state       <= ST_RESP;
                    end else begin
                        state       <= ST_DRAW;
                    end
                end
                // SCAN guarantees at least one unlocked way, so the fallback is always legal.
                ST_DRAW: begin
                    draw_cnt <= draw_cnt + 1'b1;
                    if (cand_ok) begin
                        resp_way    <= cand;
                        resp_random <= 1'b1;
                        resp_valid  <= 1'b1;
                        state       <= ST_RESP;
                    end else if (draw_cnt == CNT_W'(MAX_DRAWS - 1)) begin
                        resp_way    <= lowest_index(~lock_q);
                        resp_random <= 1'b0;
                        resp_valid  <= 1'b1;
                        state       <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_random_victim_ctrl.sv
// Scoreboard bench for random_victim_ctrl: stimulus pushes expected responses,
// per-instance monitors pop and compare whenever resp_valid is presented.
module tb_random_victim_ctrl;

    typedef struct {
        logic [1:0] way;
        logic       rnd;
        logic       none;
        int         start;
        int         lat;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid, req_ready, resp_valid, resp_ready;
    logic [3:0] valid_vec, lock_vec;
    logic [1:0] resp_way;
    logic       resp_random, resp_none, seed_load;
    logic [4:0] seed_value, lfsr_state;

    logic       m1_req_valid, m1_req_ready, m1_resp_valid, m1_resp_ready;
    logic [3:0] m1_valid_vec, m1_lock_vec;
    logic [1:0] m1_resp_way;
    logic       m1_resp_random, m1_resp_none, m1_seed_load;
    logic [4:0] m1_seed_value, m1_lfsr_state;

    exp_t main_q[$];
    exp_t m1_q[$];
    int   assertions = 0;
    int   failures   = 0;
    int   cycle_cnt  = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    random_victim_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .valid_vec   (valid_vec),
        .lock_vec    (lock_vec),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_way    (resp_way),
        .resp_random (resp_random),
        .resp_none   (resp_none),
        .seed_load   (seed_load),
        .seed_value  (seed_value),
        .lfsr_state  (lfsr_state)
    );

    random_victim_ctrl #(.MAX_DRAWS(1)) dut_m1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (m1_req_valid),
        .req_ready   (m1_req_ready),
        .valid_vec   (m1_valid_vec),
        .lock_vec    (m1_lock_vec),
        .resp_valid  (m1_resp_valid),
        .resp_ready  (m1_resp_ready),
        .resp_way    (m1_resp_way),
        .resp_random (m1_resp_random),
        .resp_none   (m1_resp_none),
        .seed_load   (m1_seed_load),
        .seed_value  (m1_seed_value),
        .lfsr_state  (m1_lfsr_state)
    );

    task automatic checkOutput(input string name, input int actual, input int expected);
        assertions++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic reportTimeout(input string name);
        assertions++;
        failures++;
        $display("[TB] FAIL %s: timed out waiting for DUT (t=%0t)", name, $time);
    endtask

    task automatic checkResp(input string tag, input exp_t e, input logic [1:0] way,
                             input logic rnd, input logic none, input int lat, input bit first);
        checkOutput({tag, "_way"}, way, e.way);
        checkOutput({tag, "_random"}, rnd, e.rnd);
        checkOutput({tag, "_none"}, none, e.none);
        if (first) checkOutput({tag, "_latency"}, lat, e.lat);
    endtask

    // Main-instance monitor: first cycle of a response pops, later cycles check hold.
    exp_t main_cur;
    bit   main_seen = 0;
    always @(negedge clk) begin
        if (!rst_n || !resp_valid) begin
            main_seen = 0;
        end else if (!main_seen) begin
            if (main_q.size() == 0) begin
                reportTimeout("main_unexpected_resp");
            end else begin
                main_cur = main_q.pop_front();
                checkResp("main", main_cur, resp_way, resp_random, resp_none,
                          cycle_cnt - main_cur.start, 1'b1);
            end
            main_seen = 1;
        end else begin
            checkResp("main_hold", main_cur, resp_way, resp_random, resp_none, 0, 1'b0);
        end
    end

    exp_t m1_cur;
    bit   m1_seen = 0;
    always @(negedge clk) begin
        if (!rst_n || !m1_resp_valid) begin
            m1_seen = 0;
        end else if (!m1_seen) begin
            if (m1_q.size() == 0) begin
                reportTimeout("m1_unexpected_resp");
            end else begin
                m1_cur = m1_q.pop_front();
                checkResp("m1", m1_cur, m1_resp_way, m1_resp_random, m1_resp_none,
                          cycle_cnt - m1_cur.start, 1'b1);
            end
            m1_seen = 1;
        end
    end

    // Issue one request; vectors are scrambled after accept to prove they were latched.
    task automatic applyStimulus(input logic [3:0] v, input logic [3:0] l, input logic [1:0] way,
                                 input logic rnd, input logic none, input int lat, input bit push);
        exp_t e;
        int   n = 0;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            reportTimeout("req_ready");
            return;
        end
        valid_vec = v;
        lock_vec  = l;
        req_valid = 1'b1;
        if (push) begin
            e.way = way; e.rnd = rnd; e.none = none; e.start = cycle_cnt; e.lat = lat;
            main_q.push_back(e);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        valid_vec = ~v;
        lock_vec  = ~l;
    endtask

    task automatic waitIdle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(req_ready && !resp_valid) && n < 60);
        if (!(req_ready && !resp_valid)) reportTimeout("wait_idle");
    endtask

    task automatic loadSeed(input logic [4:0] v, input logic [4:0] expected);
        @(negedge clk);
        seed_load  = 1'b1;
        seed_value = v;
        @(posedge clk);
        #1;
        seed_load = 1'b0;
        @(negedge clk);
        checkOutput("seed_load_lfsr", lfsr_state, expected);
    endtask

    initial begin
        exp_t e;
        int   n;
        rst_n = 1'b0;
        req_valid = 0; valid_vec = 0; lock_vec = 0; resp_ready = 1; seed_load = 0; seed_value = 0;
        m1_req_valid = 0; m1_valid_vec = 0; m1_lock_vec = 0; m1_resp_ready = 1;
        m1_seed_load = 0; m1_seed_value = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_lfsr", lfsr_state, 5'h1f);
        checkOutput("rst_req_ready", req_ready, 1);
        checkOutput("rst_resp_valid", resp_valid, 0);
        checkOutput("rst_resp_way", resp_way, 0);
        checkOutput("rst_resp_random", resp_random, 0);
        checkOutput("rst_resp_none", resp_none, 0);
        rst_n = 1'b1;

        $display("[TB] free way");
        applyStimulus(4'b1011, 4'b0000, 2'd2, 0, 0, 2, 1);
        waitIdle();
        checkOutput("free_lfsr_hold", lfsr_state, 5'h1f);

        $display("[TB] single random draw");
        applyStimulus(4'hf, 4'b0000, 2'd3, 1, 0, 3, 1);
        waitIdle();
        checkOutput("draw1_lfsr", lfsr_state, 5'h0f);

        $display("[TB] zero seed replaced by default");
        loadSeed(5'h00, 5'h1f);

        $display("[TB] locked-way rejection");
        applyStimulus(4'hf, 4'b1000, 2'd1, 1, 0, 6, 1);
        waitIdle();
        checkOutput("draw4_lfsr", lfsr_state, 5'h15);

        $display("[TB] all ways locked");
        applyStimulus(4'b0101, 4'hf, 2'd0, 0, 1, 2, 1);
        waitIdle();
        checkOutput("none_lfsr_hold", lfsr_state, 5'h15);

        $display("[TB] MAX_DRAWS=1 fallback");
        @(negedge clk);
        m1_valid_vec = 4'hf;
        m1_lock_vec  = 4'b1000;
        m1_req_valid = 1'b1;
        e.way = 2'd0; e.rnd = 0; e.none = 0; e.start = cycle_cnt; e.lat = 3;
        m1_q.push_back(e);
        @(posedge clk);
        #1;
        m1_req_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(m1_req_ready && !m1_resp_valid) && n < 60);
        if (!(m1_req_ready && !m1_resp_valid)) reportTimeout("m1_wait_idle");
        checkOutput("m1_lfsr", m1_lfsr_state, 5'h0f);

        $display("[TB] backpressure");
        resp_ready = 1'b0;
        applyStimulus(4'b0111, 4'b0000, 2'd3, 0, 0, 2, 1);
        n = 0;
        while (!resp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!resp_valid) reportTimeout("bp_resp_valid");
        repeat (5) begin
            @(negedge clk);
            checkOutput("bp_req_ready", req_ready, 0);
            checkOutput("bp_resp_valid", resp_valid, 1);
        end
        resp_ready = 1'b1;
        waitIdle();

        $display("[TB] seed_load during DRAW ignored");
        loadSeed(5'h1f, 5'h1f);
        applyStimulus(4'hf, 4'b1000, 2'd1, 1, 0, 6, 1);
        @(posedge clk);
        @(negedge clk);
        seed_load  = 1'b1;
        seed_value = 5'h05;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        seed_load = 1'b0;
        waitIdle();
        checkOutput("draw_seed_ignored_lfsr", lfsr_state, 5'h15);

        $display("[TB] reset during DRAW");
        loadSeed(5'h1f, 5'h1f);
        applyStimulus(4'hf, 4'b1000, 2'd0, 0, 0, 0, 0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_lfsr", lfsr_state, 5'h1f);
        checkOutput("midrst_req_ready", req_ready, 1);
        checkOutput("midrst_resp_valid", resp_valid, 0);
        checkOutput("midrst_resp_random", resp_random, 0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] request after reset");
        applyStimulus(4'b0000, 4'b0001, 2'd1, 0, 0, 2, 1);
        waitIdle();

        checkOutput("main_queue_empty", main_q.size(), 0);
        checkOutput("m1_queue_empty", m1_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
